lcd_cmd_sequencer: RTL and testbench

Command scheduler in front of the LCD image controller. It buffers image-processing commands from a host in a small FIFO and issues them one at a time on the controller's cmd/cmd_valid interface, obeying its busy handshake. It also detects controller stalls with watchdogs and reports progress. It sits between the testbench/host command source and the LCD controller. The IROM/IRAM paths pass directly between the controller and the memories and do not go through this block.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_cmd_fifo.sv | 65 ++++++
 rtl/lcd_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes, sequencer
// states and the command validity check.
package lcd_pkg;

    // 4-bit command codes understood by the LCD image controller decoder
    typedef enum logic [3:0] {
        CMD_WR  = 4'd0,
        CMD_SU  = 4'd1,
        CMD_SD  = 4'd2,
        CMD_SL  = 4'd3,
        CMD_SR  = 4'd4,
        CMD_MAX = 4'd5,
        CMD_MIN = 4'd6,
        CMD_AVG = 4'd7,
        CMD_CCW = 4'd8,
        CMD_CW  = 4'd9,
        CMD_MX  = 4'd10,
        CMD_MY  = 4'd11
    } lcd_cmd_t;

    // Command sequencer states
    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_RUN,
        S_ERR
    } seq_state_t;

    // Highest legal command code; anything above is dropped at the input
    localparam logic [3:0] CMD_LAST = 4'd11;

    function automatic logic cmd_is_valid(input logic [3:0] code);
        return (code <= CMD_LAST);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with registered read data. A push while full is taken
// when a pop happens in the same cycle, since the pop frees the slot.
module lcd_cmd_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read port; holds the last popped entry until the next pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (do_pop) begin
            rdata <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the LCD controller,
// following its busy handshake, with a shared watchdog for stalls.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int RUN_TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    host_cmd,
    input  logic                          host_valid,
    output logic                          host_ready,
    output logic [3:0]                    cmd,
    output logic                          cmd_valid,
    input  logic                          lcd_busy,
    input  logic                          lcd_done,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic [7:0]                    issued_cnt,
    output logic                          seq_idle,
    output logic                          err_timeout
);

    localparam int WD_MAX = (ACK_TIMEOUT > RUN_TIMEOUT) ? ACK_TIMEOUT : RUN_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    // Loaded with N-1 so the timeout fires after exactly N cycles in the state
    localparam logic [WD_W-1:0] WD_ACK = WD_W'(ACK_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_RUN = WD_W'(RUN_TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   wd_val;
    logic              wd_load;
    logic              boot_seen;
    logic              done_seen;
    logic              run_done;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [3:0]        fifo_rdata;

    // Illegal codes complete the handshake but never enter the queue
    assign host_ready  = !fifo_full && !reset;
    assign fifo_push   = host_valid && host_ready && cmd_is_valid(host_cmd);

    // The registered FIFO read port doubles as the held command output
    assign cmd         = fifo_rdata;
    assign cmd_valid   = (state == S_ISSUE);
    assign seq_idle    = (state == S_IDLE) && fifo_empty;
    assign err_timeout = (state == S_ERR);

    lcd_cmd_fifo #(
        .DATA_W (4),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .wdata  (host_cmd),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (q_count)
    );

    // Next-state, pop and watchdog reload decisions
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        run_done   = 1'b0;
        wd_load    = 1'b0;
        wd_val     = WD_RUN;
        case (state)
            S_BOOT: begin
                if (lcd_busy) begin
                    if (!boot_seen) begin
                        wd_load = 1'b1;           // IROM load started: bound its length
                    end else if (wd == '0) begin
                        state_next = S_ERR;
                    end
                end else if (boot_seen || wd == '0) begin
                    state_next = S_IDLE;          // load finished, or never started
                end
            end
            S_IDLE: begin
                if (!fifo_empty && !lcd_busy) begin
                    fifo_pop   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_ACK;
            end
            S_ACK: begin
                if (lcd_busy) begin
                    state_next = S_RUN;
                end else if (wd == '0) begin
                    state_next = S_ERR;
                end
            end
            S_RUN: begin
                if (!lcd_busy) begin
                    if (fifo_rdata == CMD_WR && !(done_seen || lcd_done)) begin
                        state_next = S_ERR;       // write ended without its done pulse
                    end else begin
                        state_next = S_IDLE;
                        run_done   = 1'b1;
                    end
                end else if (wd == '0) begin
                    state_next = S_ERR;
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
        if (state_next != state) begin
            wd_load = 1'b1;
            wd_val  = (state_next == S_ACK) ? WD_ACK : WD_RUN;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Shared watchdog down-counter; boot first waits ACK_TIMEOUT for busy to rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= WD_ACK;
        end else if (wd_load) begin
            wd <= wd_val;
        end else if (wd != '0) begin
            wd <= wd - 1'b1;
        end
    end

    // Remember busy during boot and done during a run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_seen <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (state == S_BOOT && lcd_busy) boot_seen <= 1'b1;
            if (state != S_RUN)              done_seen <= 1'b0;
            else if (lcd_done)               done_seen <= 1'b1;
        end
    end

    // Completed-command counter, wraps at 255
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt <= '0;
        end else if (run_done) begin
            issued_cnt <= issued_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a simple LCD controller model.
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [3:0] q_count;
    logic [7:0] issued_cnt;
    logic       seq_idle;
    logic       err_timeout;

    // Controller model controls
    logic       m_busy = 1'b0;
    logic       h_busy = 1'b0;
    logic       m_done = 1'b0;
    int         busy_len = 1;
    int         done_at = 0;
    bit         no_busy = 1'b0;
    logic [3:0] log_q [$];

    int         n_assert = 0;
    int         n_fail = 0;
    logic [3:0] bp_codes [9];

    assign lcd_busy = m_busy | h_busy;
    assign lcd_done = m_done;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .FIFO_DEPTH  (8),
        .ACK_TIMEOUT (4),
        .RUN_TIMEOUT (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_cmd    (host_cmd),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .lcd_busy    (lcd_busy),
        .lcd_done    (lcd_done),
        .q_count     (q_count),
        .issued_cnt  (issued_cnt),
        .seq_idle    (seq_idle),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int k = 0;
        while (cmd_valid !== 1'b1 && k < max) begin
            step();
            k++;
        end
        check(tag, cmd_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (seq_idle !== 1'b1 && k < max) begin
            step();
            k++;
        end
        check(tag, seq_idle, 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cmd"}, cmd, 0);
        check({pfx, "_cmd_valid"}, cmd_valid, 0);
        check({pfx, "_host_ready"}, host_ready, 0);
        check({pfx, "_q_count"}, q_count, 0);
        check({pfx, "_issued"}, issued_cnt, 0);
        check({pfx, "_seq_idle"}, seq_idle, 0);
        check({pfx, "_err"}, err_timeout, 0);
    endtask

    // Controller model: logs every strobe, raises busy two cycles later
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (cmd_valid === 1'b1) begin
                log_q.push_back(cmd);
                if (!no_busy) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    m_busy = 1'b1;
                    for (int k = 1; k <= busy_len; k++) begin
                        m_done = (k == done_at);
                        @(posedge clk);
                        #1;
                    end
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: observed no end expected end of test");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int k;
        bp_codes = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 4'd2};

        // Reset state
        step(2);
        check_reset_vals("rst");

        // Boot: IROM load keeps busy high for 66 cycles
        h_busy = 1'b1;
        reset  = 1'b0;
        step(1);
        check("boot_not_idle", seq_idle, 0);
        step(65);
        h_busy = 1'b0;
        step(1);
        check("boot_idle", seq_idle, 1);
        check("boot_no_strobe", log_q.size(), 0);

        // Single shift command, busy for one cycle
        busy_len = 1;
        push(4'd1);
        wait_valid("ss_strobe", 10);
        check("ss_cmd", cmd, 1);
        step(1);
        check("ss_one_cycle", cmd_valid, 0);
        wait_idle("ss_idle", 20);
        check("ss_issued", issued_cnt, 1);
        check("ss_strobes", log_q.size(), 1);

        // Back-pressure: fill the FIFO while the controller is busy
        busy_len = 3;
        h_busy   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_cmd   = bp_codes[i];
            host_valid = 1'b1;
            step();
        end
        host_cmd = bp_codes[8];
        check("bp_ready_low", host_ready, 0);
        check("bp_full", q_count, 8);
        step(1);
        check("bp_ninth_held", q_count, 8);
        h_busy = 1'b0;
        step(1);
        check("bp_first_pop", q_count, 7);
        check("bp_first_cmd", cmd, 5);
        step(1);
        check("bp_ninth_in", q_count, 8);
        host_valid = 1'b0;
        k = 0;
        while (!(log_q.size() == 10 && seq_idle === 1'b1) && k < 300) begin
            step();
            k++;
        end
        check("bp_drained", log_q.size(), 10);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp_order%0d", i), log_q[1 + i], bp_codes[i]);
        end
        check("bp_issued", issued_cnt, 10);

        // Write completing with a done pulse
        busy_len = 67;
        done_at  = 66;
        push(4'd0);
        wait_valid("wr_strobe", 10);
        wait_idle("wr_idle", 200);
        check("wr_issued", issued_cnt, 11);
        check("wr_no_err", err_timeout, 0);

        // Write without done: error, no further issue
        done_at = 0;
        push(4'd0);
        wait_valid("wr2_strobe", 10);
        k = 0;
        while (err_timeout !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check("wr2_err", err_timeout, 1);
        check("wr2_issued", issued_cnt, 11);
        push(4'd2);
        step(10);
        check("wr2_no_strobe", log_q.size(), 12);
        check("wr2_queued", q_count, 1);

        // Ack timeout: boot without busy, controller never acknowledges
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wait_idle("at_boot", 20);
        no_busy = 1'b1;
        push(4'd3);
        wait_valid("at_strobe", 10);
        check("at_cmd", cmd, 3);
        step(4);
        check("at_err_early", err_timeout, 0);
        step(1);
        check("at_err", err_timeout, 1);
        push(4'd13);
        check("at_reject", q_count, 0);

        // Reset in the middle of a run with three commands queued
        no_busy  = 1'b0;
        busy_len = 20;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wait_idle("mr_boot", 20);
        push(4'd4);
        wait_valid("mr_strobe", 10);
        step(4);
        push(4'd6);
        push(4'd7);
        push(4'd8);
        check("mr_queued", q_count, 3);
        reset = 1'b1;
        #1;
        check_reset_vals("mr");
        step(1);
        reset = 1'b0;
        step(1);
        check("mr_q_after", q_count, 0);
        check("mr_ready_after", host_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
